// File: rtl/three_phase_deadtime.sv
// Three-phase complementary gate driver: per-phase OFF/DEAD/HIGH/LOW FSM with dead-time, min on-time, enable and latched fault.
// Outputs decode registered state only; a phase change reaches the opposite gate DT_CYCLES edges after the active gate drops.
module three_phase_deadtime #(
  parameter int DT_CYCLES = 8,
  parameter int MIN_ON    = 4,
  parameter int CNT_BW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fault,
  input  logic       fault_clr,
  input  logic       phaseA,
  input  logic       phaseB,
  input  logic       phaseC,
  output logic [2:0] gate_hi,
  output logic [2:0] gate_lo,
  output logic       fault_latched,
  output logic       running
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_DEAD = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  localparam logic [CNT_BW-1:0] DT_LOAD  = CNT_BW'(DT_CYCLES - 1);
  localparam logic [CNT_BW-1:0] MIN_LOAD = CNT_BW'(MIN_ON - 1);
  localparam logic [CNT_BW-1:0] CNT_ONE  = CNT_BW'(1);

  logic [2:0][1:0]        state_q, state_d;
  logic [2:0][CNT_BW-1:0] cnt_q, cnt_d;
  logic                   fault_latched_q, fault_latched_d;
  logic                   running_q, running_d;
  logic                   go;
  logic                   all_on;
  logic [2:0]             tgt;

  always_comb begin
    go      = enable & ~fault_latched_q & ~fault;
    tgt     = {phaseC, phaseB, phaseA};
    state_d = state_q;
    cnt_d   = cnt_q;
    all_on  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!go) begin
        state_d[i] = ST_OFF;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_OFF: begin
            state_d[i] = ST_DEAD;
            cnt_d[i]   = DT_LOAD;
          end
          ST_DEAD: begin
            // Destination is chosen from the input seen on the last dead cycle.
            if (cnt_q[i] != '0) begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else begin
              state_d[i] = tgt[i] ? ST_HIGH : ST_LOW;
              cnt_d[i]   = MIN_LOAD;
            end
          end
          ST_HIGH: begin
            if (cnt_q[i] != '0) begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else if (!tgt[i]) begin
              state_d[i] = ST_DEAD;
              cnt_d[i]   = DT_LOAD;
            end
          end
          ST_LOW: begin
            if (cnt_q[i] != '0) begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else if (tgt[i]) begin
              state_d[i] = ST_DEAD;
              cnt_d[i]   = DT_LOAD;
            end
          end
        endcase
      end
      if (!(state_d[i] == ST_HIGH || state_d[i] == ST_LOW)) all_on = 1'b0;
    end
    // Fault dominates a simultaneous clear.
    fault_latched_d = fault | (fault_latched_q & ~fault_clr);
    running_d       = go & all_on;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= {3{ST_OFF}};
      cnt_q           <= '0;
      fault_latched_q <= 1'b0;
      running_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      fault_latched_q <= fault_latched_d;
      running_q       <= running_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      gate_hi[i] = (state_q[i] == ST_HIGH);
      gate_lo[i] = (state_q[i] == ST_LOW);
    end
  end

  assign fault_latched = fault_latched_q;
  assign running       = running_q;

endmodule
